// File: rtl/mixcolumn_sched.sv
// rtl/mixcolumn_sched.sv - AES MixColumns sequencer sharing MIX_UNITS column mixers
// Holding register feeds the shared mixers one column group per cycle; bypass serves the final round.

module gf_mix_col (
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col[7:0];
  assign a1 = col[15:8];
  assign a2 = col[23:16];
  assign a3 = col[31:24];

  // 3x is written as xtime(x) ^ x
  assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

  assign mixed = {b3, b2, b1, b0};

endmodule

module mixcolumn_sched #(
  parameter int MIX_UNITS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int NCYC = 4 / MIX_UNITS;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t       state, state_nx;
  logic [1:0]   col_cnt;
  logic [127:0] hold_q;
  logic [127:0] out_q;
  logic [127:0] out_nx;
  logic         accept;
  logic [31:0]  sel_word [MIX_UNITS];
  logic [31:0]  mixed    [MIX_UNITS];

  // Unit u works on column col_cnt*MIX_UNITS+u of the held state
  always_comb begin
    for (int u = 0; u < MIX_UNITS; u++) begin
      sel_word[u] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      if (c / MIX_UNITS == int'(col_cnt)) begin
        sel_word[c % MIX_UNITS] = hold_q[127-32*c -: 32];
      end
    end
  end

  for (genvar u = 0; u < MIX_UNITS; u++) begin : g_mix
    gf_mix_col u_mix (
      .col   (sel_word[u]),
      .mixed (mixed[u])
    );
  end

  // Columns outside the current group keep whatever data_out already holds
  always_comb begin
    out_nx = out_q;
    for (int c = 0; c < 4; c++) begin
      if (c / MIX_UNITS == int'(col_cnt)) begin
        out_nx[127-32*c -: 32] = mixed[c % MIX_UNITS];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = bypass ? DONE : MIX;
        end
      end
      MIX: begin
        if (col_cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = bypass ? DONE : MIX;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        col_cnt <= 2'd0;
        if (bypass) begin
          out_q <= data_in;
        end else begin
          hold_q <= data_in;
        end
      end else if (state == MIX) begin
        out_q   <= out_nx;
        col_cnt <= (col_cnt == LAST) ? 2'd0 : col_cnt + 2'd1;
      end
    end
  end

  assign data_out = out_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mixcolumn_sched.sv
// tb/tb_mixcolumn_sched.sv - directed bench for mixcolumn_sched with 1, 2 and 4 mixers
// Three instances share stimulus; each test checks the instances relevant to it.

module tb_mixcolumn_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] data_in = '0;
  logic         bypass = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] dout1, dout2, dout4;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  localparam logic [127:0] V1 = 128'h455313db_5c220af2_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hbca14d8e_9d58dc9f_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h305dbfd4_ae52b4e0_01010101_c6c6c6c6;
  localparam logic [127:0] E2 = 128'he5816604_9a19cbe0_01010101_c6c6c6c6;
  localparam logic [127:0] V3 = 128'h00112233_44556677_8899aabb_ccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mixcolumn_sched #(.MIX_UNITS(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .bypass(bypass), .out_valid(out_valid1),
    .out_ready(out_ready), .data_out(dout1), .busy(busy1)
  );
  mixcolumn_sched #(.MIX_UNITS(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .data_in(data_in), .bypass(bypass), .out_valid(out_valid2),
    .out_ready(out_ready), .data_out(dout2), .busy(busy2)
  );
  mixcolumn_sched #(.MIX_UNITS(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .data_in(data_in), .bypass(bypass), .out_valid(out_valid4),
    .out_ready(out_ready), .data_out(dout4), .busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bypass = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic accept(input logic [127:0] d, input logic b);
    data_in = d; bypass = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; bypass = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready1); end
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
    total++; if (dout1 !== 128'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout1); end
    // reset beats a simultaneous in_valid
    reset = 1'b1; data_in = V1; in_valid = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    step();
    total++; if (busy1 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("FAIL reset_vs_valid got=%b%b want=00", busy1, busy4); end
    total++; if (dout4 !== 128'h0) begin bad++; $display("FAIL reset_vs_valid_dout got=%h want=0", dout4); end
  endtask

  task automatic test_fips();
    do_reset();
    accept(V1, 1'b0);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) step();
      total++; if (out_valid1 !== (n >= 4)) begin bad++; $display("FAIL fips_valid1 n=%0d got=%b want=%b", n, out_valid1, n >= 4); end
      total++; if (out_valid2 !== (n >= 2)) begin bad++; $display("FAIL fips_valid2 n=%0d got=%b want=%b", n, out_valid2, n >= 2); end
      total++; if (out_valid4 !== (n >= 1)) begin bad++; $display("FAIL fips_valid4 n=%0d got=%b want=%b", n, out_valid4, n >= 1); end
      if (n < 4) begin
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL fips_in_ready_mix n=%0d got=%b want=0", n, in_ready1); end
      end
      if (n == 1) begin
        total++; if (dout1[127:96] !== E1[127:96] || dout1[31:0] !== 32'h0) begin
          bad++; $display("FAIL fips_partial got=%h want=%h...00000000", dout1, E1[127:96]);
        end
      end
    end
    total++; if (dout1 !== E1) begin bad++; $display("FAIL fips_dout1 got=%h want=%h", dout1, E1); end
    total++; if (dout2 !== E1) begin bad++; $display("FAIL fips_dout2 got=%h want=%h", dout2, E1); end
    total++; if (dout4 !== E1) begin bad++; $display("FAIL fips_dout4 got=%h want=%h", dout4, E1); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL fips_release_busy got=%b want=0", busy1); end
  endtask

  task automatic test_bypass();
    do_reset();
    accept(V3, 1'b1);
    total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b want=1", out_valid1); end
    total++; if (dout1 !== V3) begin bad++; $display("FAIL bypass_dout1 got=%h want=%h", dout1, V3); end
    total++; if (dout4 !== V3) begin bad++; $display("FAIL bypass_dout4 got=%h want=%h", dout4, V3); end
    step();
    total++; if (dout1 !== V3 || out_valid1 !== 1'b1) begin bad++; $display("FAIL bypass_hold got=%h/%b want=%h/1", dout1, out_valid1, V3); end
  endtask

  task automatic test_backpressure();
    do_reset();
    accept(V1, 1'b0);
    repeat (3) step();
    data_in = V3; bypass = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || dout1 !== E1) begin
        bad++; $display("FAIL bp_hold i=%0d got=%b/%b/%h want=1/0/%h", i, out_valid1, in_ready1, dout1, E1);
      end
    end
    in_valid = 1'b0; bypass = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (busy1 !== 1'b0 || dout1 !== E1) begin bad++; $display("FAIL bp_release got=%b/%h want=0/%h", busy1, dout1, E1); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    do_reset();
    accept(V1, 1'b0);
    for (int i = 0; i < 20 && !out_valid1; i++) step();
    total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL b2b_first_timeout got=%b want=1", out_valid1); end
    t1 = cyc;
    total++; if (dout1 !== E1) begin bad++; $display("FAIL b2b_first got=%h want=%h", dout1, E1); end
    data_in = V2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready1); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin bad++; $display("FAIL b2b_chained got=%b/%b want=1/0", busy1, out_valid1); end
    for (int i = 0; i < 20 && !out_valid1; i++) step();
    t2 = cyc;
    total++; if (t2 - t1 !== 5) begin bad++; $display("FAIL b2b_spacing got=%0d want=5", t2 - t1); end
    total++; if (dout1 !== E2) begin bad++; $display("FAIL b2b_second got=%h want=%h", dout1, E2); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    total++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b/%b want=0/0", out_valid1, busy1); end
  endtask

  task automatic test_reset_mid_mix();
    int t0;
    do_reset();
    accept(V1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (out_valid1 !== 1'b0 || dout1 !== 128'h0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++; $display("FAIL midmix_reset got=%b/%h/%b/%b want=0/0/1/0", out_valid1, dout1, in_ready1, busy1);
    end
    accept(V1, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 20 && !out_valid1; i++) step();
    total++; if (cyc - t0 !== 4) begin bad++; $display("FAIL midmix_latency got=%0d want=4", cyc - t0); end
    total++; if (dout1 !== E1) begin bad++; $display("FAIL midmix_rerun got=%h want=%h", dout1, E1); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
